sdram_port_arb: RTL and testbench
=================================

SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter ADDR_W, default 24, sets the SDRAM word address width.
REQ-002 Parameter LEN_W, default 10, sets the burst length width.
REQ-003 Parameter DATA_W, default 16, sets the data width.
REQ-004 clk  in  1  system clock (100 MHz controller domain); all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 pN_req  in  1  port N request (N = 0, 1); held high by the port until pN_gnt.
REQ-007 pN_we  in  1  port N direction: 1 = write, 0 = read.
REQ-008 pN_addr  in  ADDR_W  port N burst start address.
REQ-009 pN_len  in  LEN_W  port N burst length in words.
REQ-010 pN_wdata  in  DATA_W  port N write data, advanced by the port on each pN_ack.
REQ-011 pN_gnt  out  1  one-cycle pulse: port N request accepted and request fields sampled.
REQ-012 pN_ack  out  1  port N beat strobe; a copy of wr_ack or rd_ack while port N owns the bus.
REQ-013 pN_done  out  1  one-cycle pulse when port N's burst completes.
REQ-014 wr_req, rd_req  out  1  requests to sdram_ctrl.
REQ-015 wr_addr, rd_addr  out  ADDR_W; wr_burst_len, rd_burst_len  out  LEN_W; wr_data  out  DATA_W; these drive sdram_ctrl.
REQ-016 wr_ack, rd_ack  in  1  per-beat acknowledges from sdram_ctrl; rd_data is routed directly from sdram_ctrl to the ports, not through this block.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, XFER, DONE.
REQ-018 IDLE: when any pN_req is high, the FSM SHALL pick a winner and pulse its pN_gnt.
  - Grant pulse and sampling of we/addr/len into owner registers SHALL occur in the same cycle.
  - Transition: to ISSUE when len != 0; to DONE when len == 0.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, the port not granted last wins; after reset, port 0 wins first.
REQ-020 ISSUE: the block SHALL hold wr_req (if we = 1) or rd_req (if we = 0) high until the first matching ack, then enter XFER.
  - The first ack SHALL count as beat 1.
  - The other request line SHALL stay low.
REQ-021 Address and length outputs SHALL carry the owner's sampled values from the first ISSUE cycle until leaving XFER, and SHALL be zero otherwise.
REQ-022 wr_data SHALL combinationally mux the owner's pN_wdata while owned; otherwise it SHALL be 0.
REQ-023 A beat counter (LEN_W bits) SHALL count matching acks.
  - When the ack for beat == len arrives, the FSM SHALL go to DONE.
  - Acks in excess of len SHALL be ignored.
REQ-024 Acks of the non-owned direction, or any ack seen in IDLE or DONE, SHALL be ignored and not forwarded.
REQ-025 DONE: pN_done SHALL pulse for one cycle, then the FSM SHALL return to IDLE.
  - Minimum gap between consecutive grants: 1 cycle (in IDLE).
REQ-026 Owner registers and pN_we/pN_addr/pN_len SHALL not be resampled mid-burst; a port's deasserted pN_req after grant SHALL not affect the burst.

Reset
REQ-027 On rst_n low, the block SHALL immediately enter IDLE.
  - All outputs SHALL go to 0 and the beat counter SHALL clear.
  - The round-robin pointer SHALL reset so that port 0 wins first.
REQ-028 Reset mid-burst SHALL drop wr_req/rd_req at once without a pN_done pulse; sdram_ctrl is reset by the same rst_n.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding and the default widths (ADDR_W, LEN_W, DATA_W).
REQ-030 The round-robin selector SHALL be one sub-module, rr_arb2 (req[1:0], last-grant pointer -> one-hot grant).

Verification
REQ-031 p0 write, addr 0x000010, len 10, against the SDRAM model -> p0_gnt 1 cycle, then wr_req high until first wr_ack, then 10 p0_ack, then p0_done once; wr_addr = 0x000010 throughout.
REQ-032 p0 write and p1 read raised in the same cycle after reset -> p0 granted first, p1 granted 1 cycle after p0_done; read-back of p1 (same address) matches p0 data.
REQ-033 Both ports request continuously for 8 bursts -> grants alternate p0, p1, p0, ...; no overlap between wr_req and rd_req.
REQ-034 p1 read with len = 0 -> p1_gnt, then p1_done 1 cycle later; rd_req never asserted.
REQ-035 rst_n pulsed low during beat 5 of a len-10 write -> all outputs 0 within the same cycle; no p0_done; a following request from p0 is granted normally.
REQ-036 Spurious rd_ack injected during a write burst -> not forwarded; beat count and done timing unchanged.

Source files
------------

// File: rtl/sdram_port_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter: default widths and
// the FSM state encoding.
package sdram_port_arb_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int LEN_W_DEF  = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector. On a tie the port that was not granted
// last wins; a lone requester always wins. The grant is one-hot (or zero).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,   // index of the port granted most recently
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/sdram_port_arb.sv
// Two-port front end for sdram_ctrl. Grants one port at a time, forwards
// its burst request to the write or read channel, strobes the owner's beat
// acks and pulses done when the burst length has been acknowledged.
module sdram_port_arb
  import sdram_port_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [LEN_W-1:0]  p0_len,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_ack,
  output logic              p0_done,
  // port 1
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [LEN_W-1:0]  p1_len,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic              p1_done,
  // sdram_ctrl side
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_burst_len,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_burst_len,
  input  logic              rd_ack
);

  state_t            state;
  logic              own_port;   // 0 = port 0 owns the bus, 1 = port 1
  logic              own_we;
  logic [LEN_W-1:0]  own_len;
  logic [LEN_W-1:0]  beat;
  logic [LEN_W-1:0]  next_beat;
  logic              last_gnt;
  logic [1:0]        arb_gnt;
  logic              busy;
  logic              match_ack;

  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  rr_arb2 u_rr_arb2 (
    .req  ({p1_req, p0_req}),
    .last (last_gnt),
    .gnt  (arb_gnt)
  );

  // A burst is in flight from the first ISSUE cycle to the last XFER cycle;
  // only then are acks forwarded and write data routed.
  assign busy      = (state == ISSUE) || (state == XFER);
  assign match_ack = own_we ? wr_ack : rd_ack;
  assign next_beat = beat + LEN_W'(1);

  assign p0_ack  = busy && !own_port && match_ack;
  assign p1_ack  = busy &&  own_port && match_ack;
  assign wr_data = busy ? (own_port ? p1_wdata : p0_wdata) : '0;

  // Request fields of the port the arbiter would grant this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first) so no latch is inferred.
    sel_port = 1'b0;
    sel_we   = p0_we;
    sel_addr = p0_addr;
    sel_len  = p0_len;
    if (arb_gnt[1]) begin
      sel_port = 1'b1;
      sel_we   = p1_we;
      sel_addr = p1_addr;
      sel_len  = p1_len;
    end
  end

  // Burst FSM with registered grant/done pulses and channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_gnt     <= 1'b1;   // port 1 "granted last" so port 0 wins first
      own_port     <= 1'b0;
      own_we       <= 1'b0;
      own_len      <= '0;
      beat         <= '0;
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      p0_done      <= 1'b0;
      p1_done      <= 1'b0;
      wr_req       <= 1'b0;
      rd_req       <= 1'b0;
      wr_addr      <= '0;
      wr_burst_len <= '0;
      rd_addr      <= '0;
      rd_burst_len <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            p0_gnt   <= arb_gnt[0];
            p1_gnt   <= arb_gnt[1];
            last_gnt <= sel_port;
            own_port <= sel_port;
            own_we   <= sel_we;
            own_len  <= sel_len;
            beat     <= '0;
            if (sel_len == '0) begin
              state <= DONE;
            end else begin
              state  <= ISSUE;
              wr_req <= sel_we;
              rd_req <= !sel_we;
              if (sel_we) begin
                wr_addr      <= sel_addr;
                wr_burst_len <= sel_len;
              end else begin
                rd_addr      <= sel_addr;
                rd_burst_len <= sel_len;
              end
            end
          end
        end
        ISSUE, XFER: begin
          // The first matching ack is beat 1 and releases the request line.
          if (match_ack) begin
            beat   <= next_beat;
            wr_req <= 1'b0;
            rd_req <= 1'b0;
            if (next_beat == own_len) begin
              state        <= DONE;
              wr_addr      <= '0;
              wr_burst_len <= '0;
              rd_addr      <= '0;
              rd_burst_len <= '0;
            end else begin
              state <= XFER;
            end
          end
        end
        DONE: begin
          p0_done <= !own_port;
          p1_done <= own_port;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb: a cycle table for the basic
// handshakes followed by burst sequences against a small SDRAM memory model.
module tb_sdram_port_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [23:0] p0_addr = '0;
  logic [9:0]  p0_len = '0;
  logic [15:0] p0_wdata = '0;
  logic        p0_gnt, p0_ack, p0_done;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [23:0] p1_addr = '0;
  logic [9:0]  p1_len = '0;
  logic [15:0] p1_wdata = '0;
  logic        p1_gnt, p1_ack, p1_done;
  logic        wr_req, rd_req;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [15:0] wr_data;
  logic        wr_ack = 1'b0, rd_ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sdram_port_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_len       (p0_len),
    .p0_wdata     (p0_wdata),
    .p0_gnt       (p0_gnt),
    .p0_ack       (p0_ack),
    .p0_done      (p0_done),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_len       (p1_len),
    .p1_wdata     (p1_wdata),
    .p1_gnt       (p1_gnt),
    .p1_ack       (p1_ack),
    .p1_done      (p1_done),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_burst_len (wr_burst_len),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_ack       (rd_ack)
  );

  // One table row is one clock cycle: inputs, then expected strobes packed as
  // {p0_gnt,p0_ack,p0_done,p1_gnt,p1_ack,p1_done,wr_req,rd_req}.
  typedef struct {
    bit         p0_req;
    bit         p0_we;
    logic [9:0] p0_len;
    bit         p1_req;
    bit         p1_we;
    logic [9:0] p1_len;
    bit         wr_ack;
    bit         rd_ack;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] flags();
    return {p0_gnt, p0_ack, p0_done, p1_gnt, p1_ack, p1_done, wr_req, rd_req};
  endfunction

  function automatic logic [7:0] mk(input int port, input bit g, input bit a, input bit d,
                                    input bit wq, input bit rq);
    logic [7:0] v;
    v = '0;
    if (port == 0) v[7:5] = {g, a, d};
    else           v[4:2] = {g, a, d};
    v[1:0] = {wq, rq};
    return v;
  endfunction

  function automatic logic [23:0] out_addr(input bit we);
    return we ? wr_addr : rd_addr;
  endfunction

  function automatic logic [9:0] out_len(input bit we);
    return we ? wr_burst_len : rd_burst_len;
  endfunction

  task automatic drop_req(input int port);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
    #1;
    check("reset_flags", 64'(flags()), 64'(0));
    check("reset_wr_addr", 64'(wr_addr), 64'(0));
    check("reset_rd_len", 64'(rd_burst_len), 64'(0));
    check("reset_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one burst for a port whose request is already raised and which wins
  // at the next edge. lat = idle cycles before the first ack, spur = beat
  // index carrying an opposite-direction ack (-1 for none). Writes store
  // wr_data into mem; reads expect mem to hold dbase+beat.
  task automatic run_burst(input int port, input bit we, input logic [23:0] addr,
                           input logic [9:0] len, input int lat, input int spur,
                           input logic [15:0] dbase);
    logic [7:0]  idx;
    logic [15:0] dval;
    // grant cycle
    @(negedge clk);
    wr_ack = 1'b0; rd_ack = 1'b0;
    #1;
    check("grant", 64'(flags()), 64'(mk(port, 1, 0, 0, we && len != 0, !we && len != 0)));
    if (len == 0) begin
      @(negedge clk);
      drop_req(port);
      #1;
      check("len0_done", 64'(flags()), 64'(mk(port, 0, 0, 1, 0, 0)));
      return;
    end
    check("issue_addr", 64'(out_addr(we)), 64'(addr));
    check("issue_len", 64'(out_len(we)), 64'(len));
    for (int w = 0; w < lat; w++) begin
      @(negedge clk);
      drop_req(port);
      #1;
      check("wait_req", 64'(flags()), 64'(mk(port, 0, 0, 0, we, !we)));
    end
    for (int b = 0; b < int'(len); b++) begin
      @(negedge clk);
      drop_req(port);
      dval = dbase + 16'(b);
      wr_ack = we ? 1'b1 : (b == spur);
      rd_ack = we ? (b == spur) : 1'b1;
      if (port == 0) begin p0_wdata = dval; p1_wdata = ~dval; end
      else           begin p1_wdata = dval; p0_wdata = ~dval; end
      #1;
      check("beat", 64'(flags()), 64'(mk(port, 0, 1, 0, we && b == 0, !we && b == 0)));
      check("beat_addr", 64'(out_addr(we)), 64'(addr));
      if (we) begin
        check("wr_data", 64'(wr_data), 64'(dval));
        idx = addr[7:0] + 8'(b);
        mem[idx] = wr_data;
      end else begin
        idx = rd_addr[7:0] + 8'(b);
        check("read_back", 64'(mem[idx]), 64'(dval));
      end
    end
    // DONE state: an excess ack must be ignored
    @(negedge clk);
    wr_ack = we; rd_ack = !we;
    #1;
    check("done_state", 64'(flags()), 64'(mk(port, 0, 0, 0, 0, 0)));
    check("done_addr", 64'(out_addr(we)), 64'(0));
    @(negedge clk);
    wr_ack = 1'b0; rd_ack = 1'b0;
    #1;
    check("done_pulse", 64'(flags()), 64'(mk(port, 0, 0, 1, 0, 0)));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;

    tbl = '{
      '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'b000_000_00},
      '{1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 8'b000_000_00},
      '{1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 8'b000_100_00},
      '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'b000_001_00},
      '{1'b1, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 8'b000_000_00},
      '{1'b1, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b0, 1'b1, 8'b100_000_10},
      '{1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 8'b010_000_10},
      '{1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b1, 1'b1, 8'b010_000_00},
      '{1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b1, 1'b0, 8'b000_000_00},
      '{1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 8'b001_000_00},
      '{1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 1'b0, 1'b0, 8'b000_100_01},
      '{1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd1, 1'b1, 1'b1, 8'b000_010_01},
      '{1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd1, 1'b0, 1'b0, 8'b000_000_00},
      '{1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd1, 1'b0, 1'b0, 8'b000_001_00},
      '{1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd1, 1'b0, 1'b0, 8'b000_000_00}
    };

    do_reset();

    // table: len-0 read on p1, tie won by p0, spurious and excess acks
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      p0_req = tbl[i].p0_req; p0_we = tbl[i].p0_we; p0_len = tbl[i].p0_len;
      p1_req = tbl[i].p1_req; p1_we = tbl[i].p1_we; p1_len = tbl[i].p1_len;
      wr_ack = tbl[i].wr_ack; rd_ack = tbl[i].rd_ack;
      #1;
      check($sformatf("vec%0d", i), 64'(flags()), 64'(tbl[i].exp));
    end

    // p0 write of 10 words at 0x10, one wait cycle, spurious rd_ack on beat 5
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 24'h000010; p0_len = 10'd10;
    #1;
    check("pre_grant", 64'(flags()), 64'(0));
    run_burst(0, 1'b1, 24'h000010, 10'd10, 1, 4, 16'hA000);

    // simultaneous p0 write / p1 read of the same address after reset
    do_reset();
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 24'h000040; p0_len = 10'd4;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000040; p1_len = 10'd4;
    #1;
    check("tie_pre", 64'(flags()), 64'(0));
    run_burst(0, 1'b1, 24'h000040, 10'd4, 1, 2, 16'hB000);
    run_burst(1, 1'b0, 24'h000040, 10'd4, 2, 1, 16'hB000);

    // both ports requesting continuously: grants alternate p0, p1, ...
    p0_addr = 24'h000080; p0_len = 10'd2;
    p1_len = 10'd3;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        run_burst(0, 1'b1, 24'h000080, 10'd2, 0, -1, 16'hC000 + 16'(k * 16));
        p0_req = 1'b1;
      end else begin
        run_burst(1, 1'b0, 24'h000040, 10'd3, 1, -1, 16'hB000);
        p1_req = 1'b1;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // reset during beat 5 of a 10-word write
    @(negedge clk);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 24'h000020; p0_len = 10'd10;
    @(negedge clk);
    #1;
    check("rst_grant", 64'(flags()), 64'(mk(0, 1, 0, 0, 1, 0)));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      p0_req = 1'b0; wr_ack = 1'b1; p0_wdata = 16'h5500 + 16'(b);
      #1;
      check("rst_beat", 64'(flags()), 64'(mk(0, 0, 1, 0, b == 0, 0)));
    end
    @(negedge clk);
    wr_ack = 1'b1; p0_wdata = 16'h5504;
    rst_n = 1'b0;
    #1;
    check("rst_flags", 64'(flags()), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_len", 64'(wr_burst_len), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; wr_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("rst_no_done", 64'(flags()), 64'(0));
    end
    @(negedge clk);
    p0_req = 1'b1; p0_addr = 24'h000030; p0_len = 10'd2;
    p1_req = 1'b0;
    #1;
    check("post_rst_pre", 64'(flags()), 64'(0));
    run_burst(0, 1'b1, 24'h000030, 10'd2, 0, -1, 16'h6600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
